// File: rtl/mips_debug_pkg.sv
// Shared types and constants for the debug step controller.
// Build option: DEBUG_CYCLE_COUNT_EN appends a cycle counter to every report.
package mips_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_LATCH,
    ST_SEND,
    ST_DONE
  } state_e;

  localparam logic [7:0] CMD_RUN_DEF    = 8'h63;
  localparam logic [7:0] CMD_STEP_DEF   = 8'h73;
  localparam logic [7:0] CMD_REPORT_DEF = 8'h72;

  // Number of bytes in one report: PC only, or PC followed by the cycle counter.
  function automatic int report_bytes(input int data_width);
`ifdef DEBUG_CYCLE_COUNT_EN
    return 2 * (data_width / 8);
`else
    return data_width / 8;
`endif
  endfunction

  localparam int REPORT_BYTES = report_bytes(32);

endpackage

// File: rtl/debug_tx_serializer.sv
// Parallel-load byte shifter with a valid/ready handshake toward the UART
// transmitter. Sends MSB first; o_done pulses on the accept of the last byte.
module debug_tx_serializer #(
  parameter int NBYTES = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [NBYTES*8-1:0]   i_load_data,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_done
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [NBYTES*8-1:0] shift_q, shift_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                valid_q, valid_d;

  // Next-state for the shifter: load, hold under back-pressure, or advance on accept.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    o_done  = 1'b0;
    if (i_load) begin
      shift_d = i_load_data;
      idx_d   = IW'(NBYTES - 1);
      valid_d = 1'b1;
    end else if (valid_q && i_tx_ready) begin
      if (idx_q == '0) begin
        // Last byte taken: clear everything so no stale byte lingers.
        shift_d = '0;
        valid_d = 1'b0;
        o_done  = 1'b1;
      end else begin
        shift_d = shift_q << 8;
        idx_d   = idx_q - 1'b1;
      end
    end
  end

  // Shifter registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_data  = shift_q[NBYTES*8-1 -: 8];
  assign o_tx_valid = valid_q;

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug-side run/step controller between the UART and the core.
// Build option: DEBUG_CYCLE_COUNT_EN adds a stepped-cycle counter to reports.
//
// state | meaning
// IDLE  | waiting for a command byte
// RUN   | free-running, o_step held high until halt is seen
// STEP  | single advance cycle in progress
// LATCH | capture PC (and counter) into the serializer
// SEND  | report bytes going out to the transmitter
// DONE  | core halted; only report requests are honoured
module debug_step_ctrl
  import mips_debug_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] CMD_RUN    = CMD_RUN_DEF,
  parameter logic [7:0] CMD_STEP   = CMD_STEP_DEF,
  parameter logic [7:0] CMD_REPORT = CMD_REPORT_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_haltsignal,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_tx_ready,
  output logic                  o_start,
  output logic                  o_step,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_busy
);

  localparam int NBYTES = report_bytes(DATA_WIDTH);

  state_e state_q, state_d;
  logic   start_q, start_d;
  logic   step_q, step_d;
  logic   load;
  logic   tx_done;
  logic [NBYTES*8-1:0] load_data;

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

  // Count cycles in which the pipeline actually advanced.
  always_comb begin
    cnt_d = cnt_q;
    if (step_q && !i_haltsignal) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge i_clock) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign load_data = {i_pc, cnt_q};
`else
  assign load_data = i_pc;
`endif

  // Command decode and sequencing; commands arriving outside IDLE/DONE are dropped.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    step_d  = step_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_RUN) begin
            start_d = 1'b1;
            step_d  = 1'b1;
            state_d = ST_RUN;
          end else if (i_rx_data == CMD_STEP) begin
            // A halted core cannot advance, so a step just reports.
            if (i_haltsignal) begin
              state_d = ST_LATCH;
            end else begin
              start_d = 1'b1;
              step_d  = 1'b1;
              state_d = ST_STEP;
            end
          end else if (i_rx_data == CMD_REPORT) begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_RUN: begin
        if (i_haltsignal) begin
          step_d  = 1'b0;
          state_d = ST_LATCH;
        end
      end
      ST_STEP: begin
        step_d  = 1'b0;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done) state_d = i_haltsignal ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (i_rx_valid && i_rx_data == CMD_REPORT) state_d = ST_LATCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and enable registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      step_q  <= step_d;
    end
  end

  debug_tx_serializer #(.NBYTES(NBYTES)) u_ser (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (load),
    .i_load_data (load_data),
    .i_tx_ready  (i_tx_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .o_done      (tx_done)
  );

  assign o_start = start_q;
  assign o_step  = step_q;
  assign o_busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl; expected report bytes are queued
// when a command is issued and matched against every accepted byte.
module tb_debug_step_ctrl;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_haltsignal = 1'b0;
  logic [31:0] i_pc = 32'h0;
  logic        i_tx_ready = 1'b1;
  logic        o_start, o_step, o_tx_valid, o_busy;
  logic [7:0]  o_tx_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  debug_step_ctrl dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_haltsignal (i_haltsignal),
    .i_pc         (i_pc),
    .i_tx_ready   (i_tx_ready),
    .o_start      (o_start),
    .o_step       (o_step),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .o_busy       (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Byte monitor: every accepted byte must be the next expected one.
  always @(negedge i_clock) begin
    if (!i_reset && o_tx_valid && i_tx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got byte %02h, expected no byte", o_tx_data);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (o_tx_data !== exp) begin
          errors++;
          $display("FAIL tx_byte: got %02h, expected %02h", o_tx_data, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) sb.push_back(w[i*8 +: 8]);
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    i_rx_valid   = 1'b0;
    i_haltsignal = 1'b0;
    i_tx_ready   = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_idle(input int max, output int steps);
    bit ok;
    steps = 0;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
      if (o_step) steps++;
    end
    if (!ok && o_busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy=%b, expected 0", o_busy);
    end
  endtask

  task automatic wait_valid(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (o_tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok && !o_tx_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout: got valid=%b, expected 1", o_tx_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_start !== 1'b0)    begin errors++; $display("FAIL rst_start: got %b expected 0", o_start); end
    checks++; if (o_step !== 1'b0)     begin errors++; $display("FAIL rst_step: got %b expected 0", o_step); end
    checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_tx_valid); end
    checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h expected 00", o_tx_data); end
    checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_step();
    int steps;
    i_pc = 32'h0000_0004;
    i_tx_ready = 1'b1;
    push_word(32'h0000_0004);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h0000_0001);
`endif
    send_cmd(8'h73);
    checks++; if (o_step !== 1'b1)  begin errors++; $display("FAIL step_pulse: got %b expected 1", o_step); end
    checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL step_start: got %b expected 1", o_start); end
    checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL step_busy: got %b expected 1", o_busy); end
    wait_idle(100, steps);
    checks++; if (steps != 0)       begin errors++; $display("FAIL step_extra_cycles: got %0d expected 0", steps); end
    checks++; if (sb.size() != 0)   begin errors++; $display("FAIL step_bytes_left: got %0d expected 0", sb.size()); end
    checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL step_start_sticky: got %b expected 1", o_start); end
    checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL step_valid_end: got %b expected 0", o_tx_valid); end
  endtask

  task automatic test_run();
    int low;
    int steps;
    do_reset();
    i_pc = 32'h0000_0050;
    push_word(32'h0000_0050);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h0000_0014);
`endif
    send_cmd(8'h63);
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_step !== 1'b1) low++;
      tick();
    end
    checks++; if (low != 0)         begin errors++; $display("FAIL run_step_low: got %0d low cycles expected 0", low); end
    i_haltsignal = 1'b1;
    checks++; if (o_step !== 1'b1)  begin errors++; $display("FAIL run_step_at_halt: got %b expected 1", o_step); end
    tick();
    checks++; if (o_step !== 1'b0)  begin errors++; $display("FAIL run_step_after_halt: got %b expected 0", o_step); end
    checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL run_busy_latch: got %b expected 1", o_busy); end
    wait_idle(100, steps);
    checks++; if (steps != 0)       begin errors++; $display("FAIL run_steps_in_send: got %0d expected 0", steps); end
    checks++; if (sb.size() != 0)   begin errors++; $display("FAIL run_bytes_left: got %0d expected 0", sb.size()); end
    checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL run_start: got %b expected 1", o_start); end
  endtask

  task automatic test_done_cmds();
    int steps;
    send_cmd(8'h63);
    checks++; if (o_step !== 1'b0)  begin errors++; $display("FAIL done_c_step: got %b expected 0", o_step); end
    checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL done_c_busy: got %b expected 0", o_busy); end
    tick();
    send_cmd(8'h73);
    checks++; if (o_step !== 1'b0)  begin errors++; $display("FAIL done_s_step: got %b expected 0", o_step); end
    checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL done_s_busy: got %b expected 0", o_busy); end
    tick();
    push_word(32'h0000_0050);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h0000_0014);
`endif
    send_cmd(8'h72);
    checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL done_r_busy: got %b expected 1", o_busy); end
    wait_idle(100, steps);
    checks++; if (steps != 0)       begin errors++; $display("FAIL done_r_steps: got %0d expected 0", steps); end
    checks++; if (sb.size() != 0)   begin errors++; $display("FAIL done_r_bytes_left: got %0d expected 0", sb.size()); end
    checks++; if (o_start !== 1'b1) begin errors++; $display("FAIL done_start: got %b expected 1", o_start); end
  endtask

  task automatic test_ignore_during_send();
    int steps;
    do_reset();
    i_pc = 32'h1234_5678;
    push_word(32'h1234_5678);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h0000_0000);
`endif
    send_cmd(8'h72);
    wait_valid(20);
    send_cmd(8'h73);
    checks++; if (o_step !== 1'b0)  begin errors++; $display("FAIL ign_step: got %b expected 0", o_step); end
    wait_idle(100, steps);
    checks++; if (steps != 0)       begin errors++; $display("FAIL ign_steps: got %0d expected 0", steps); end
    checks++; if (sb.size() != 0)   begin errors++; $display("FAIL ign_bytes_left: got %0d expected 0", sb.size()); end
    tick();
    checks++; if (o_busy !== 1'b0 || o_step !== 1'b0) begin errors++; $display("FAIL ign_after: got busy=%b step=%b expected 0 0", o_busy, o_step); end
  endtask

  task automatic test_backpressure();
    int steps;
    int bad;
    do_reset();
    i_pc = 32'hA1B2_C3D4;
    push_word(32'hA1B2_C3D4);
`ifdef DEBUG_CYCLE_COUNT_EN
    push_word(32'h0000_0000);
`endif
    i_tx_ready = 1'b0;
    send_cmd(8'h72);
    wait_valid(20);
    checks++; if (o_tx_data !== 8'hA1) begin errors++; $display("FAIL bp_first: got %02h expected a1", o_tx_data); end
    i_tx_ready = 1'b1;
    tick();
    i_tx_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hB2) bad++;
      tick();
    end
    checks++; if (bad != 0)         begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    checks++; if (o_tx_data !== 8'hB2) begin errors++; $display("FAIL bp_hold_end: got %02h expected b2", o_tx_data); end
    i_tx_ready = 1'b1;
    wait_idle(100, steps);
    checks++; if (sb.size() != 0)   begin errors++; $display("FAIL bp_bytes_left: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_pc = 32'hDEAD_BEEF;
    i_tx_ready = 1'b0;
    send_cmd(8'h73);
    wait_valid(20);
    checks++; if (o_tx_data !== 8'hDE) begin errors++; $display("FAIL rm_first: got %02h expected de", o_tx_data); end
    checks++; if (o_start !== 1'b1)    begin errors++; $display("FAIL rm_start_before: got %b expected 1", o_start); end
    i_reset = 1'b1;
    tick();
    checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", o_tx_valid); end
    checks++; if (o_start !== 1'b0)    begin errors++; $display("FAIL rm_start: got %b expected 0", o_start); end
    checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL rm_busy: got %b expected 0", o_busy); end
    i_reset = 1'b0;
    i_tx_ready = 1'b1;
    tick();
    tick();
    checks++; if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rm_after: got valid=%b busy=%b expected 0 0", o_tx_valid, o_busy); end
    checks++; if (sb.size() != 0)      begin errors++; $display("FAIL rm_bytes_left: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run();
    test_done_cmds();
    test_ignore_during_send();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_step_ctrl.md
Name: debug_step_ctrl

Overview:
- Debug-side controller driving the pipeline's run/step enables (o_start, o_step) into the program counter and stall logic.
- Decodes one-byte commands from the UART receiver: run continuously, single-step, report.
- On halt or after each single step, serialises the current PC (and optionally a cycle count) back to the UART transmitter as bytes, MSB first.
- Sits between uart_rx/uart_tx and the MIPS core top level.

Parameters:
- DATA_WIDTH, 32, PC and cycle-counter width; must be a multiple of 8.
- CMD_RUN, 8'h63, command byte 'c': continuous run.
- CMD_STEP, 8'h73, command byte 's': single step.
- CMD_REPORT, 8'h72, command byte 'r': send report without advancing.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_rx_data  in  8  received command byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
- i_haltsignal  in  1  core has retired HALT; level, sticky until reset.
- i_pc  in  DATA_WIDTH  current PC value from the core.
- i_tx_ready  in  1  transmitter can accept a byte this cycle.
- o_start  out  1  program launched; sticky.
- o_step  out  1  pipeline advance enable.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data is valid.
- o_busy  out  1  high in any state other than IDLE or DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, cycle counter 0, shift register 0. Reset mid-transfer aborts the transfer immediately; no partial byte is held.
- States: IDLE, RUN, STEP, LATCH, SEND, DONE.
- IDLE:
  - CMD_RUN: o_start<=1, o_step<=1, go to RUN.
  - CMD_STEP: o_start<=1, o_step<=1 for exactly one cycle, go to STEP.
  - CMD_REPORT: go to LATCH.
  - Any other byte is ignored.
- RUN: o_step held at 1. When i_haltsignal is sampled 1, o_step<=0 on the next edge and the state goes to LATCH.
- STEP: o_step<=0, go to LATCH. Exactly one advance per 's' command.
- LATCH: one cycle. Loads i_pc into the shift register, plus the counter when the optional feature is on. Go to SEND.
- SEND: byte-serial transfer, MSB first.
  - o_tx_valid=1 and o_tx_data=current byte, held stable until i_tx_ready=1 is sampled with o_tx_valid=1.
  - On that accept, advance to the next byte on the following cycle; no bubble is required between bytes.
  - After the last accept, o_tx_valid<=0. Next state is DONE if i_haltsignal=1, else IDLE.
- DONE: o_start stays 1, o_step stays 0. CMD_RUN and CMD_STEP are ignored; CMD_REPORT goes to LATCH.
- Command acceptance: i_rx_valid is ignored in RUN, STEP, LATCH and SEND. Commands are not queued.
- Single step with halt already set: 's' in IDLE while i_haltsignal=1 behaves as 'r'; o_step is not asserted.
- o_start never falls except on reset.

Optional Feature:
- Macro: DEBUG_CYCLE_COUNT_EN.
- Defined:
  - DATA_WIDTH-bit counter increments on every cycle with o_step=1 and i_haltsignal=0; wraps modulo 2^DATA_WIDTH.
  - Report is PC bytes followed by counter bytes: 8 bytes at the default width.
- Undefined: no counter; report is PC bytes only (4 bytes at the default width).

Decomposition:
- Package mips_debug_pkg holds the state enum, default command codes, and REPORT_BYTES derived from DATA_WIDTH and the macro.
- Sub-module debug_tx_serializer: parallel load plus valid/ready byte shifter. It owns o_tx_data, o_tx_valid, the byte index and the done pulse.

Test Plan:
- Reset, then 's' with i_pc=32'h0000_0004 and i_tx_ready=1 -> o_step high exactly 1 cycle; o_start=1; bytes 00,00,00,04 out; return to IDLE.
- 'c', then i_haltsignal raised 20 cycles later with i_pc=32'h0000_0050 -> o_step high until the cycle after halt; report 00,00,00,50; state DONE. With DEBUG_CYCLE_COUNT_EN, the report is followed by counter bytes 00,00,00,14.
- 's' sent during SEND -> ignored: no extra o_step pulse; byte stream unchanged.
- i_tx_ready held 0 for 5 cycles on byte 2 -> o_tx_data and o_tx_valid stable throughout; byte 2 emitted once when ready rises.
- In DONE: 'c' and 's' -> o_step stays 0. Then 'r' -> report resent with the same PC.
- i_reset asserted during SEND byte 1 -> next cycle o_tx_valid=0, o_start=0, state IDLE.
